// File: rtl/disp_scan.sv
// Multiplexed 7-segment display scanner. Each digit slot starts with a short
// blanked interval, and each frame's digit data is frozen when the frame starts.
module disp_scan #(
    parameter int DIGITS    = 8,
    parameter int CODE_W    = 6,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16,
    parameter int ACT_LOW   = 1
) (
    input  logic                     clk_DISP,
    input  logic                     rst_n,
    input  logic [DIGITS*CODE_W-1:0] digit_codes,
    input  logic [DIGITS-1:0]        dot_mask,
    input  logic                     enable,
    output logic [6:0]               seg,
    output logic                     dp,
    output logic [DIGITS-1:0]        an,
    output logic                     frame_tick
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
    localparam logic          INV        = (ACT_LOW != 0);

    logic [PW-1:0]     presc;
    logic [IW-1:0]     idx;
    logic              slot_wrap;
    logic              frame_wrap;
    logic [CODE_W-1:0] snap_code [DIGITS];
    logic [DIGITS-1:0] snap_dot;
    logic              lit;
    logic [6:0]        seg_nxt;
    logic              dp_nxt;
    logic [DIGITS-1:0] an_nxt;

    function automatic logic [6:0] seg_decode(input logic [CODE_W-1:0] code);
        logic [6:0] pat;
        case (code)
            CODE_W'(0):     pat = 7'h3F;
            CODE_W'(1):     pat = 7'h06;
            CODE_W'(2):     pat = 7'h5B;
            CODE_W'(3):     pat = 7'h4F;
            CODE_W'(4):     pat = 7'h66;
            CODE_W'(5):     pat = 7'h6D;
            CODE_W'(6):     pat = 7'h7D;
            CODE_W'(7):     pat = 7'h07;
            CODE_W'(8):     pat = 7'h7F;
            CODE_W'(9):     pat = 7'h6F;
            CODE_W'(10):    pat = 7'h40;
            CODE_W'(11):    pat = 7'h79;
            CODE_W'(6'h3E): pat = 7'h73;
            CODE_W'(6'h3C): pat = 7'h76;
            CODE_W'(6'h3B): pat = 7'h5E;
            CODE_W'(6'h3A): pat = 7'h48;
            default:        pat = 7'h00;
        endcase
        return pat;
    endfunction

    always_comb begin
        slot_wrap  = (presc == PRESC_LAST);
        frame_wrap = slot_wrap && (idx == IDX_LAST);
        lit        = enable && (presc >= BLANK_END);
        seg_nxt    = '0;
        dp_nxt     = 1'b0;
        an_nxt     = '0;
        if (lit) begin
            seg_nxt     = seg_decode(snap_code[idx]);
            dp_nxt      = snap_dot[idx];
            an_nxt[idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_DISP or negedge rst_n) begin
        if (!rst_n) begin
            presc      <= '0;
            idx        <= '0;
            frame_tick <= 1'b0;
            snap_dot   <= '0;
            for (int unsigned k = 0; k < DIGITS; k++) snap_code[k] <= '1;
        end else begin
            frame_tick <= frame_wrap;
            if (slot_wrap) begin
                presc <= '0;
                idx   <= frame_wrap ? '0 : idx + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end
            // Snapshot shares the edge that moves idx back to 0, so the frame
            // being finished still uses the old data on its last cycle.
            if (frame_wrap) begin
                snap_dot <= dot_mask;
                for (int unsigned k = 0; k < DIGITS; k++)
                    snap_code[k] <= digit_codes[k*CODE_W +: CODE_W];
            end
        end
    end

    always_ff @(posedge clk_DISP or negedge rst_n) begin
        if (!rst_n) begin
            seg <= {7{INV}};
            dp  <= INV;
            an  <= {DIGITS{INV}};
        end else begin
            seg <= seg_nxt ^ {7{INV}};
            dp  <= dp_nxt ^ INV;
            an  <= an_nxt ^ {DIGITS{INV}};
        end
    end

endmodule

// File: tb/tb_disp_scan.sv
// Bench for disp_scan: an arithmetic cycle-count model checked every cycle on an
// active-high and an active-low instance, plus hand-computed pin values.
module tb_disp_scan;

    localparam int DIG = 4;
    localparam int CW  = 6;
    localparam int SD  = 8;
    localparam int BC  = 2;

    logic              clk_DISP = 1'b0;
    logic              rst_n    = 1'b1;
    logic [DIG*CW-1:0] codes;
    logic [DIG-1:0]    dots;
    logic              enable;
    logic [6:0]        seg0, seg1;
    logic              dp0, dp1, tick0, tick1;
    logic [DIG-1:0]    an0, an1;

    always #5 clk_DISP = ~clk_DISP;

    disp_scan #(.DIGITS(DIG), .CODE_W(CW), .SCAN_DIV(SD), .BLANK_CYC(BC), .ACT_LOW(0)) u_hi (
        .clk_DISP(clk_DISP), .rst_n(rst_n), .digit_codes(codes), .dot_mask(dots),
        .enable(enable), .seg(seg0), .dp(dp0), .an(an0), .frame_tick(tick0)
    );

    disp_scan #(.DIGITS(DIG), .CODE_W(CW), .SCAN_DIV(SD), .BLANK_CYC(BC), .ACT_LOW(1)) u_lo (
        .clk_DISP(clk_DISP), .rst_n(rst_n), .digit_codes(codes), .dot_mask(dots),
        .enable(enable), .seg(seg1), .dp(dp1), .an(an1), .frame_tick(tick1)
    );

    logic [6:0] dec_tab [64];
    initial begin
        for (int i = 0; i < 64; i++) dec_tab[i] = 7'h00;
        dec_tab[0]  = 7'h3F; dec_tab[1]  = 7'h06; dec_tab[2]  = 7'h5B; dec_tab[3] = 7'h4F;
        dec_tab[4]  = 7'h66; dec_tab[5]  = 7'h6D; dec_tab[6]  = 7'h7D; dec_tab[7] = 7'h07;
        dec_tab[8]  = 7'h7F; dec_tab[9]  = 7'h6F; dec_tab[10] = 7'h40; dec_tab[11] = 7'h79;
        dec_tab[62] = 7'h73; dec_tab[60] = 7'h76; dec_tab[59] = 7'h5E; dec_tab[58] = 7'h48;
    end

    // t = clock edges since reset release; slot, position and frame follow by division.
    int unsigned       t;
    logic [DIG*CW-1:0] msnap;
    logic [DIG-1:0]    mdot;
    logic [6:0]        exp_seg;
    logic              exp_dp, exp_tick;
    logic [DIG-1:0]    exp_an;

    always @(posedge clk_DISP or negedge rst_n) begin
        if (!rst_n) begin
            t <= 0; msnap <= '1; mdot <= '0;
            exp_seg <= '0; exp_dp <= 1'b0; exp_an <= '0; exp_tick <= 1'b0;
        end else begin
            if (enable && (t % SD) >= BC) begin
                exp_an  <= 4'(1 << ((t / SD) % DIG));
                exp_seg <= dec_tab[msnap[((t / SD) % DIG) * CW +: CW]];
                exp_dp  <= mdot[(t / SD) % DIG];
            end else begin
                exp_an <= '0; exp_seg <= '0; exp_dp <= 1'b0;
            end
            exp_tick <= ((t + 1) % (SD * DIG)) == 0;
            if (((t + 1) % (SD * DIG)) == 0) begin
                msnap <= codes;
                mdot  <= dots;
            end
            t <= t + 1;
        end
    end

    int tests = 0;
    int fails = 0;
    logic checking = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s at t=%0d: got %h, expected %h", name, t, act, req);
        end
    endtask

    always @(negedge clk_DISP) begin
        if (checking) begin
            chk("an_hi",   {28'h0, an0},  {28'h0, exp_an});
            chk("seg_hi",  {25'h0, seg0}, {25'h0, exp_seg});
            chk("dp_hi",   {31'h0, dp0},  {31'h0, exp_dp});
            chk("tick_hi", {31'h0, tick0}, {31'h0, exp_tick});
            chk("an_lo",   {28'h0, an1},  {28'h0, ~exp_an});
            chk("seg_lo",  {25'h0, seg1}, {25'h0, ~exp_seg});
            chk("dp_lo",   {31'h0, dp1},  {31'h0, ~exp_dp});
            chk("tick_lo", {31'h0, tick1}, {31'h0, exp_tick});
        end
    end

    task automatic run_to(input int unsigned n);
        for (int i = 0; i < 400 && t < n; i++) @(negedge clk_DISP);
        if (t != n) chk("run_to_timeout", t, n);
    endtask

    task automatic pin(input string name, input logic [3:0] an_v, input logic [6:0] seg_v);
        chk({name, "_an"},  {28'h0, an0},  {28'h0, an_v});
        chk({name, "_seg"}, {25'h0, seg0}, {25'h0, seg_v});
    endtask

    task automatic dark_now(input string name);
        chk({name, "_an_hi"},  {28'h0, an0},  32'h0);
        chk({name, "_seg_hi"}, {25'h0, seg0}, 32'h0);
        chk({name, "_dp_hi"},  {31'h0, dp0},  32'h0);
        chk({name, "_an_lo"},  {28'h0, an1},  32'hF);
        chk({name, "_seg_lo"}, {25'h0, seg1}, 32'h7F);
        chk({name, "_dp_lo"},  {31'h0, dp1},  32'h1);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, got t=%0d, expected completion", t);
        $fatal(1, "watchdog");
    end

    initial begin
        codes  = {6'd4, 6'd3, 6'd2, 6'd1};
        dots   = 4'b0000;
        enable = 1'b1;
        #1 rst_n = 1'b0;
        #1 checking = 1'b1;
        repeat (3) @(negedge clk_DISP);
        dark_now("reset");
        chk("reset_tick", {31'h0, tick0}, 32'h0);
        #2 rst_n = 1'b1;

        // first frame shows blank codes, anodes still scan
        run_to(10); pin("f0_blank_int", 4'b0000, 7'h00);
        run_to(12); pin("f0_slot1", 4'b0010, 7'h00);
        run_to(32); chk("tick32", {31'h0, tick0}, 32'h1);
        run_to(33); chk("tick33", {31'h0, tick0}, 32'h0);
        run_to(34); pin("f1_d0_blank", 4'b0000, 7'h00);
        run_to(35); pin("f1_d0_first", 4'b0001, 7'h06);
        run_to(44); pin("f1_d1", 4'b0010, 7'h5B);

        // change inputs mid-frame: no tearing
        run_to(50); codes = {6'd8, 6'd7, 6'd6, 6'd5};
        run_to(52); pin("f1_d2_old", 4'b0100, 7'h4F);
        run_to(60); pin("f1_d3_old", 4'b1000, 7'h66);
        run_to(64); chk("tick64", {31'h0, tick0}, 32'h1);
        run_to(68); pin("f2_d0_new", 4'b0001, 7'h6D);
        run_to(76); pin("f2_d1_new", 4'b0010, 7'h7D);

        // special codes and decimal point
        run_to(84); pin("f2_d2_new", 4'b0100, 7'h07);
        codes = {6'h25, 6'h3A, 6'd11, 6'd10};
        dots  = 4'b0010;
        run_to(92);  pin("f2_d3_new", 4'b1000, 7'h7F);
        run_to(100); pin("f3_dash", 4'b0001, 7'h40);
        chk("f3_d0_dp", {31'h0, dp0}, 32'h0);
        run_to(105); chk("f3_d1_dp_blank", {31'h0, dp0}, 32'h0);
        run_to(107); chk("f3_d1_dp_on", {31'h0, dp0}, 32'h1);
        run_to(108); pin("f3_E", 4'b0010, 7'h79);
        run_to(116); pin("f3_eq", 4'b0100, 7'h48);
        chk("f3_d2_dp", {31'h0, dp0}, 32'h0);
        run_to(124); pin("f3_undef", 4'b1000, 7'h00);

        // enable low for 20 cycles mid-frame
        run_to(133); enable = 1'b0;
        run_to(140); pin("dis_dark", 4'b0000, 7'h00);
        run_to(153); enable = 1'b1;
        run_to(156); pin("resume_d3", 4'b1000, 7'h00);
        run_to(159); chk("tick159", {31'h0, tick0}, 32'h0);
        run_to(160); chk("tick160", {31'h0, tick0}, 32'h1);
        run_to(164); pin("f5_d0", 4'b0001, 7'h40);

        // async reset inside an active window
        run_to(165);
        #2 rst_n = 1'b0;
        #1 dark_now("async_rst");
        repeat (2) @(negedge clk_DISP);
        #2 rst_n = 1'b1;
        run_to(12); pin("post_rst_blank", 4'b0010, 7'h00);
        run_to(32); chk("post_rst_tick", {31'h0, tick0}, 32'h1);
        run_to(36); pin("post_rst_f1", 4'b0001, 7'h40);
        run_to(40);

        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
